// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side drain stage for the synchronous FIFO. It issues read strobes,
// absorbs the FIFO's one-cycle registered read latency in a 3-entry elastic
// buffer and presents the words as a valid/ready stream. The read strobe is
// derived only from registered occupancy, en and fifo_empty, so m_ready never
// reaches fifo_rd_en combinationally.
// Optional build macro: RD_STREAM_STATS_EN adds the beat_cnt output, a
// free-running count of accepted beats (wraps modulo 2^CNT_WIDTH).
module fifo_rd_stream #(
  parameter int DWIDTH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_out_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              idle
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] beat_cnt
`endif
);

  // Elaboration-time sanity check on the statistics counter width.
  if (CNT_WIDTH < 1) begin : gCntWidthCheck
    $error("fifo_rd_stream: CNT_WIDTH must be at least 1");
  end

  logic [DWIDTH-1:0] r_buf [3];
  logic [1:0]        r_cnt;
  logic [1:0]        r_wrPtr;
  logic [1:0]        r_rdPtr;
  logic              r_inflight;

  logic [2:0]        w_occupancy;
  logic              w_pop;
  logic [1:0]        w_wrPtrNext;
  logic [1:0]        w_rdPtrNext;

  // Read issue and stream handshake; occupancy counts the word still in flight
  // so the buffer can never be overrun.
  always_comb begin
    w_occupancy = {1'b0, r_cnt} + {2'b00, r_inflight};
    fifo_rd_en  = en && !fifo_empty && (w_occupancy < 3'd3);
    m_valid     = (r_cnt != 2'd0);
    m_data      = r_buf[r_rdPtr];
    w_pop       = m_valid && m_ready;
    idle        = (r_cnt == 2'd0) && !r_inflight;
    w_wrPtrNext = (r_wrPtr == 2'd2) ? 2'd0 : r_wrPtr + 2'd1;
    w_rdPtrNext = (r_rdPtr == 2'd2) ? 2'd0 : r_rdPtr + 2'd1;
  end

  // Buffer state: capture the FIFO word one cycle after its read, pop on
  // handshake, and keep the occupancy count in step with both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= 2'd0;
      r_wrPtr    <= 2'd0;
      r_rdPtr    <= 2'd0;
      r_inflight <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= fifo_rd_en;
      if (r_inflight) begin
        r_buf[r_wrPtr] <= fifo_out_data;
        r_wrPtr        <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

`ifdef RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] r_beatCnt;

  // Accepted-beat counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beatCnt <= '0;
    end else if (w_pop) begin
      r_beatCnt <= r_beatCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign beat_cnt = r_beatCnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream with a behavioural synchronous FIFO
// (registered read data, shared async reset) feeding the DUT.
// Build with RD_STREAM_STATS_EN defined to also exercise beat_cnt.
module tb_fifo_rd_stream;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_out_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          idle;
`ifdef RD_STREAM_STATS_EN
  logic [CW-1:0] beat_cnt;
`endif

  int numCompared   = 0;
  int numMismatched = 0;

  logic [DW-1:0] fMem [64];
  int            fWr = 0;
  int            fRd;

  fifo_rd_stream #(
    .DWIDTH    (DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_out_data (fifo_out_data),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .idle          (idle)
`ifdef RD_STREAM_STATS_EN
    ,
    .beat_cnt      (beat_cnt)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  assign fifo_empty = (fWr == fRd);

  // Behavioural FIFO read port: one-cycle registered read data, reset with the DUT.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fRd           <= 0;
      fifo_out_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_out_data <= fMem[fRd % 64];
      fRd           <= fRd + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [DW-1:0] v);
    fMem[fWr % 64] = v;
    fWr = fWr + 1;
  endtask

  task automatic doReset();
    en      = 1'b0;
    m_ready = 1'b0;
    rstn    = 1'b0;
    fWr     = 0;
    #12;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    en      = 1'b1;
    m_ready = 1'b1;
    fWr     = 0;
    #1;
    rstn = 1'b0;
    #1;
    numCompared++;
    if (fifo_rd_en !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL reset fifo_rd_en: got %b expected 0", fifo_rd_en);
    end
    numCompared++;
    if (m_valid !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL reset m_valid: got %b expected 0", m_valid);
    end
    numCompared++;
    if (m_data !== 4'h0) begin
      numMismatched++;
      $display("[TB] FAIL reset m_data: got %h expected 0", m_data);
    end
    numCompared++;
    if (idle !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL reset idle: got %b expected 1", idle);
    end
`ifdef RD_STREAM_STATS_EN
    numCompared++;
    if (beat_cnt !== 4'h0) begin
      numMismatched++;
      $display("[TB] FAIL reset beat_cnt: got %h expected 0", beat_cnt);
    end
`endif
    en      = 1'b0;
    m_ready = 1'b0;
    #10;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_drain4();
    int expRd    [7] = '{1, 1, 1, 1, 0, 0, 0};
    int expValid [7] = '{0, 0, 1, 1, 1, 1, 0};
    int expData  [7] = '{0, 0, 1, 2, 3, 4, 0};
    int expIdle  [7] = '{1, 0, 0, 0, 0, 0, 1};
    doReset();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) pushWord(DW'(i));
    en = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      numCompared++;
      if (fifo_rd_en !== expRd[k][0]) begin
        numMismatched++;
        $display("[TB] FAIL drain4 fifo_rd_en c%0d: got %b expected %0d", k, fifo_rd_en, expRd[k]);
      end
      numCompared++;
      if (m_valid !== expValid[k][0]) begin
        numMismatched++;
        $display("[TB] FAIL drain4 m_valid c%0d: got %b expected %0d", k, m_valid, expValid[k]);
      end
      numCompared++;
      if (idle !== expIdle[k][0]) begin
        numMismatched++;
        $display("[TB] FAIL drain4 idle c%0d: got %b expected %0d", k, idle, expIdle[k]);
      end
      if (expValid[k] == 1) begin
        numCompared++;
        if (m_data !== DW'(expData[k])) begin
          numMismatched++;
          $display("[TB] FAIL drain4 m_data c%0d: got %h expected %0h", k, m_data, expData[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    doReset();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pushWord(DW'(i));
    en = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (fifo_rd_en === 1'b1) reads++;
      tick();
    end
    numCompared++;
    if (reads !== 3) begin
      numMismatched++;
      $display("[TB] FAIL backpressure read count: got %0d expected 3", reads);
    end
    numCompared++;
    if (fifo_rd_en !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL backpressure fifo_rd_en held: got %b expected 0", fifo_rd_en);
    end
    numCompared++;
    if (m_valid !== 1'b1 || m_data !== 4'h1) begin
      numMismatched++;
      $display("[TB] FAIL backpressure hold: got valid %b data %h expected valid 1 data 1", m_valid, m_data);
    end
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      numCompared++;
      if (m_valid !== 1'b1 || m_data !== DW'(k + 1)) begin
        numMismatched++;
        $display("[TB] FAIL backpressure release beat%0d: got valid %b data %h expected valid 1 data %0h", k, m_valid, m_data, k + 1);
      end
      tick();
    end
    numCompared++;
    if (m_valid !== 1'b0 || idle !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL backpressure drained: got valid %b idle %b expected valid 0 idle 1", m_valid, idle);
    end
  endtask

  task automatic test_alternate();
    logic [DW-1:0] expSeq [12];
    int txIdx = 0;
    int rxIdx = 0;
    doReset();
    for (int i = 0; i < 12; i++) expSeq[i] = DW'((i * 3 + 1) % 16);
    en = 1'b1;
    for (int cyc = 0; cyc < 100 && rxIdx < 12; cyc++) begin
      if (txIdx < 12) begin
        pushWord(expSeq[txIdx]);
        txIdx++;
      end
      m_ready = cyc[0];
      #1;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        numCompared++;
        if (m_data !== expSeq[rxIdx]) begin
          numMismatched++;
          $display("[TB] FAIL alternate beat%0d: got %h expected %h", rxIdx, m_data, expSeq[rxIdx]);
        end
        rxIdx++;
      end
      tick();
    end
    numCompared++;
    if (rxIdx !== 12) begin
      numMismatched++;
      $display("[TB] FAIL alternate beat count: got %0d expected 12", rxIdx);
    end
    m_ready = 1'b1;
    tick();
    numCompared++;
    if (m_valid !== 1'b0 || idle !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL alternate no extra beat: got valid %b idle %b expected valid 0 idle 1", m_valid, idle);
    end
  endtask

  task automatic test_en_drop();
    doReset();
    m_ready = 1'b1;
    pushWord(4'h7);
    pushWord(4'h8);
    pushWord(4'h9);
    en = 1'b1;
    #1;
    numCompared++;
    if (fifo_rd_en !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL en_drop first read: got %b expected 1", fifo_rd_en);
    end
    tick();
    en = 1'b0;
    #1;
    numCompared++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL en_drop c1: got rd %b valid %b expected rd 0 valid 0", fifo_rd_en, m_valid);
    end
    tick();
    numCompared++;
    if (m_valid !== 1'b1 || m_data !== 4'h7 || fifo_rd_en !== 1'b0) begin
      numMismatched++;
      $display("[TB] FAIL en_drop inflight word: got valid %b data %h rd %b expected valid 1 data 7 rd 0", m_valid, m_data, fifo_rd_en);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      numCompared++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || idle !== 1'b1) begin
        numMismatched++;
        $display("[TB] FAIL en_drop quiet c%0d: got rd %b valid %b idle %b expected rd 0 valid 0 idle 1", k, fifo_rd_en, m_valid, idle);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    doReset();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pushWord(DW'(i + 10));
    en = 1'b1;
    tick();
    tick();
    tick();
    numCompared++;
    if (m_valid !== 1'b1 || idle !== 1'b0 || m_data !== 4'hB) begin
      numMismatched++;
      $display("[TB] FAIL reset_mid setup: got valid %b idle %b data %h expected valid 1 idle 0 data b", m_valid, idle, m_data);
    end
    rstn = 1'b0;
    fWr  = 0;
    #1;
    numCompared++;
    if (m_valid !== 1'b0 || idle !== 1'b1) begin
      numMismatched++;
      $display("[TB] FAIL reset_mid async: got valid %b idle %b expected valid 0 idle 1", m_valid, idle);
    end
    #2;
    rstn    = 1'b1;
    m_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (m_valid !== 1'b0) stale++;
      tick();
    end
    numCompared++;
    if (stale !== 0) begin
      numMismatched++;
      $display("[TB] FAIL reset_mid stale beats: got %0d expected 0", stale);
    end
  endtask

`ifdef RD_STREAM_STATS_EN
  task automatic test_stats();
    int pops = 0;
    doReset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) pushWord(DW'(i));
    en = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && pops < 17; cyc++) begin
      if (m_valid === 1'b1 && m_ready === 1'b1) pops++;
      tick();
    end
    numCompared++;
    if (pops !== 17) begin
      numMismatched++;
      $display("[TB] FAIL stats pop count: got %0d expected 17", pops);
    end
    numCompared++;
    if (beat_cnt !== 4'h1) begin
      numMismatched++;
      $display("[TB] FAIL stats beat_cnt wrap: got %h expected 1", beat_cnt);
    end
  endtask
`endif

  // Test sequence, then the single summary line.
  initial begin
    en      = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_drain4();
    test_backpressure();
    test_alternate();
    test_en_drop();
    test_reset_mid();
`ifdef RD_STREAM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
